// File: rtl/sp_sram_arbiter.sv
// ---------------------------------------------------------------------------
// sp_sram_arbiter
//   Round-robin access controller for two requesters (A, B) sharing one
//   single-port SRAM with 1-cycle read latency. After reset it zero-fills
//   the whole array, then grants one access at most every second cycle.
//
// Ports
//   iClk, iRsn                 clock (rising edge), async active-low reset
//   iReqX/iWrnX/iAddrX/iWrDtX  request handshake + command of requester X
//   oGntX                      1-cycle pulse: request accepted
//   oErrX                      pulses with oGntX when address >= SRAM_DEPTH
//   oRdVldX                    1-cycle pulse: oRdDt carries X's read data
//   oRdDt                      read data (forced 0 after an errored read)
//   oInitDone                  high once the zero-fill has completed
//   oSramCsn/Wrn/Addr/WrDt     registered SRAM command pins
//   iSramRdDt                  SRAM read data
// ---------------------------------------------------------------------------
module sp_sram_arbiter #(
  parameter int SRAM_DEPTH = 10,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  iClk,
  input  logic                  iRsn,
  input  logic                  iReqA,
  input  logic                  iWrnA,
  input  logic [ADDR_WIDTH-1:0] iAddrA,
  input  logic [DATA_WIDTH-1:0] iWrDtA,
  input  logic                  iReqB,
  input  logic                  iWrnB,
  input  logic [ADDR_WIDTH-1:0] iAddrB,
  input  logic [DATA_WIDTH-1:0] iWrDtB,
  output logic                  oGntA,
  output logic                  oGntB,
  output logic                  oRdVldA,
  output logic                  oRdVldB,
  output logic                  oErrA,
  output logic                  oErrB,
  output logic [DATA_WIDTH-1:0] oRdDt,
  output logic                  oInitDone,
  output logic                  oSramCsn,
  output logic                  oSramWrn,
  output logic [ADDR_WIDTH-1:0] oSramAddr,
  output logic [DATA_WIDTH-1:0] oSramWrDt,
  input  logic [DATA_WIDTH-1:0] iSramRdDt
);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_ACCESS} state_t;

  // One extra bit so a depth equal to 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(SRAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SRAM_DEPTH - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  rr_b_q, rr_b_d;        // 1: B wins a collision
  logic                  win_b_q, win_b_d;      // winner of the current access
  logic                  win_rd_q, win_rd_d;    // current access is a read
  logic                  rd_err_q, rd_err_d;    // current/last access was out of range
  logic                  csn_q, csn_d;
  logic                  wrn_q, wrn_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wrdt_q, wrdt_d;
  logic                  gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
  logic                  err_a_q, err_a_d, err_b_q, err_b_d;
  logic                  rdvld_a_q, rdvld_a_d, rdvld_b_q, rdvld_b_d;
  logic                  init_done_q, init_done_d;

  // Arbitration: a lone requester always wins; on a collision the pointer decides.
  logic                  sel_b;
  logic                  sel_wrn;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wrdt;
  logic                  sel_oob;

  assign sel_b    = iReqB & (~iReqA | rr_b_q);
  assign sel_wrn  = sel_b ? iWrnB  : iWrnA;
  assign sel_addr = sel_b ? iAddrB : iAddrA;
  assign sel_wrdt = sel_b ? iWrDtB : iWrDtA;
  assign sel_oob  = ({1'b0, sel_addr} >= DEPTH_W);

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    rr_b_d      = rr_b_q;
    win_b_d     = win_b_q;
    win_rd_d    = win_rd_q;
    rd_err_d    = rd_err_q;
    csn_d       = 1'b1;
    wrn_d       = wrn_q;
    addr_d      = addr_q;
    wrdt_d      = wrdt_q;
    gnt_a_d     = 1'b0;
    gnt_b_d     = 1'b0;
    err_a_d     = 1'b0;
    err_b_d     = 1'b0;
    rdvld_a_d   = 1'b0;
    rdvld_b_d   = 1'b0;
    init_done_d = init_done_q;

    unique case (state_q)
      ST_INIT: begin
        csn_d      = 1'b0;
        wrn_d      = 1'b1;
        addr_d     = init_cnt_q;
        wrdt_d     = '0;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == LAST_ADDR) begin
          init_cnt_d  = '0;
          init_done_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (iReqA | iReqB) begin
          state_d  = ST_ACCESS;
          win_b_d  = sel_b;
          win_rd_d = ~sel_wrn;
          rd_err_d = sel_oob;
          rr_b_d   = ~sel_b;
          // Out-of-range accesses keep Csn high so the SRAM never sees them.
          csn_d    = sel_oob;
          wrn_d    = sel_wrn;
          addr_d   = sel_addr;
          wrdt_d   = sel_wrdt;
          gnt_a_d  = ~sel_b;
          gnt_b_d  = sel_b;
          err_a_d  = ~sel_b & sel_oob;
          err_b_d  = sel_b & sel_oob;
        end
      end
      ST_ACCESS: begin
        // Always back to IDLE: the winner's request is re-sampled fresh there,
        // so a held request cannot be granted twice.
        state_d   = ST_IDLE;
        rdvld_a_d = win_rd_q & ~win_b_q;
        rdvld_b_d = win_rd_q & win_b_q;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      rr_b_q      <= 1'b0;
      win_b_q     <= 1'b0;
      win_rd_q    <= 1'b0;
      rd_err_q    <= 1'b0;
      csn_q       <= 1'b1;
      wrn_q       <= 1'b0;
      addr_q      <= '0;
      wrdt_q      <= '0;
      gnt_a_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      err_a_q     <= 1'b0;
      err_b_q     <= 1'b0;
      rdvld_a_q   <= 1'b0;
      rdvld_b_q   <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      rr_b_q      <= rr_b_d;
      win_b_q     <= win_b_d;
      win_rd_q    <= win_rd_d;
      rd_err_q    <= rd_err_d;
      csn_q       <= csn_d;
      wrn_q       <= wrn_d;
      addr_q      <= addr_d;
      wrdt_q      <= wrdt_d;
      gnt_a_q     <= gnt_a_d;
      gnt_b_q     <= gnt_b_d;
      err_a_q     <= err_a_d;
      err_b_q     <= err_b_d;
      rdvld_a_q   <= rdvld_a_d;
      rdvld_b_q   <= rdvld_b_d;
      init_done_q <= init_done_d;
    end
  end

  assign oGntA     = gnt_a_q;
  assign oGntB     = gnt_b_q;
  assign oErrA     = err_a_q;
  assign oErrB     = err_b_q;
  assign oRdVldA   = rdvld_a_q;
  assign oRdVldB   = rdvld_b_q;
  assign oInitDone = init_done_q;
  assign oSramCsn  = csn_q;
  assign oSramWrn  = wrn_q;
  assign oSramAddr = addr_q;
  assign oSramWrDt = wrdt_q;
  // rd_err_q still describes the access whose data is on iSramRdDt this cycle.
  assign oRdDt     = rd_err_q ? '0 : iSramRdDt;

endmodule
